// File: rtl/filter_coe_ctrl.sv
// Double-buffered 2D filter coefficient bank: cfg writes fill the shadow bank, a commit swaps it into the active bank atomically on the next video frame start.
// Writes take effect at the accepting edge; cfg_wr_ready is low while a commit is pending or the one-cycle update is shown.
module filter_coe_ctrl #(
  parameter int FILTER_DIM = 5,
  parameter int COE_WIDTH  = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      cfg_wr_valid,
  output logic                                      cfg_wr_ready,
  input  logic [5:0]                                cfg_wr_addr,
  input  logic [COE_WIDTH-1:0]                      cfg_wr_data,
  input  logic                                      cfg_commit,
  input  logic                                      cfg_abort,
  input  logic                                      mon_tvalid,
  input  logic                                      mon_tready,
  input  logic                                      mon_tuser,
  output logic [FILTER_DIM*FILTER_DIM*COE_WIDTH-1:0] coe_flat,
  output logic                                      coe_update,
  output logic                                      cfg_pending,
  output logic                                      cfg_err
);

  localparam int         NTAP   = FILTER_DIM * FILTER_DIM;
  localparam int         CENTRE = NTAP / 2;
  localparam logic [5:0] NTAP_A = 6'(NTAP);
  localparam logic [COE_WIDTH-1:0] UNITY = {1'b0, {(COE_WIDTH-1){1'b1}}};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_UPDATE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 err_q, err_d;
  logic [COE_WIDTH-1:0] shadow_q [NTAP];
  logic [COE_WIDTH-1:0] shadow_d [NTAP];
  logic [COE_WIDTH-1:0] active_q [NTAP];
  logic [COE_WIDTH-1:0] active_d [NTAP];

  logic wr_acc;
  logic wr_oor;
  logic frame_start;
  logic swap;

  assign wr_acc      = cfg_wr_valid && (state_q == ST_IDLE);
  assign wr_oor      = wr_acc && (cfg_wr_addr >= NTAP_A);
  assign frame_start = mon_tvalid && mon_tready && mon_tuser;
  // Abort beats a coincident frame start.
  assign swap        = (state_q == ST_PENDING) && !cfg_abort && frame_start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cfg_commit) state_d = ST_PENDING;
      ST_PENDING: begin
        if (cfg_abort)        state_d = ST_IDLE;
        else if (frame_start) state_d = ST_UPDATE;
      end
      ST_UPDATE:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // An out-of-range write in the commit cycle keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && cfg_commit) err_d = 1'b0;
    if (wr_oor)                           err_d = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = active_q[k];
      if (wr_acc && cfg_wr_addr == 6'(k)) shadow_d[k] = cfg_wr_data;
      if (swap)                           active_d[k] = shadow_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      for (int k = 0; k < NTAP; k++) begin
        shadow_q[k] <= (k == CENTRE) ? UNITY : '0;
        active_q[k] <= (k == CENTRE) ? UNITY : '0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      for (int k = 0; k < NTAP; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  assign cfg_wr_ready = (state_q == ST_IDLE);
  assign cfg_pending  = (state_q == ST_PENDING);
  assign coe_update   = (state_q == ST_UPDATE);
  assign cfg_err      = err_q;

  for (genvar g = 0; g < NTAP; g++) begin : g_flat
    assign coe_flat[g*COE_WIDTH +: COE_WIDTH] = active_q[g];
  end

endmodule

// File: tb/tb_filter_coe_ctrl.sv
// Bench for filter_coe_ctrl: bank-level reference model checked every cycle plus directed literal expectations.
module tb_filter_coe_ctrl;
  localparam int FD = 5;
  localparam int CW = 16;
  localparam int NT = FD * FD;
  localparam int FW = NT * CW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_wr_valid = 1'b0;
  logic          cfg_wr_ready;
  logic [5:0]    cfg_wr_addr = '0;
  logic [CW-1:0] cfg_wr_data = '0;
  logic          cfg_commit = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          mon_tvalid = 1'b0;
  logic          mon_tready = 1'b0;
  logic          mon_tuser = 1'b0;
  logic [FW-1:0] coe_flat;
  logic          coe_update;
  logic          cfg_pending;
  logic          cfg_err;

  filter_coe_ctrl #(.FILTER_DIM(FD), .COE_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_wr_valid (cfg_wr_valid),
    .cfg_wr_ready (cfg_wr_ready),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_commit   (cfg_commit),
    .cfg_abort    (cfg_abort),
    .mon_tvalid   (mon_tvalid),
    .mon_tready   (mon_tready),
    .mon_tuser    (mon_tuser),
    .coe_flat     (coe_flat),
    .coe_update   (coe_update),
    .cfg_pending  (cfg_pending),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: two coefficient banks plus "commit waiting" and "update showing" flags.
  logic [CW-1:0] m_sh [NT];
  logic [CW-1:0] m_ac [NT];
  bit m_pend, m_upd, m_err;

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_sh[k] = (k == NT / 2) ? 16'h7FFF : 16'h0000;
      m_ac[k] = m_sh[k];
    end
    m_pend = 1'b0;
    m_upd  = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    bit ready, fs, oor, new_upd;
    ready   = !m_pend && !m_upd;
    fs      = mon_tvalid && mon_tready && mon_tuser;
    oor     = 1'b0;
    new_upd = 1'b0;
    if (ready) begin
      if (cfg_wr_valid) begin
        if (int'(cfg_wr_addr) < NT) m_sh[int'(cfg_wr_addr)] = cfg_wr_data;
        else oor = 1'b1;
      end
      if (cfg_commit) begin
        m_pend = 1'b1;
        m_err  = 1'b0;
      end
      if (oor) m_err = 1'b1;
    end else if (m_pend) begin
      if (cfg_abort) m_pend = 1'b0;
      else if (fs) begin
        for (int k = 0; k < NT; k++) m_ac[k] = m_sh[k];
        m_pend  = 1'b0;
        new_upd = 1'b1;
      end
    end
    m_upd = new_upd;
  endtask

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] p;
    for (int k = 0; k < NT; k++) p[k*CW +: CW] = m_ac[k];
    return p;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_ready",   cfg_wr_ready, !m_pend && !m_upd);
      chk("mdl_pending", cfg_pending,  m_pend);
      chk("mdl_update",  coe_update,   m_upd);
      chk("mdl_err",     cfg_err,      m_err);
      chk("mdl_flat",    coe_flat,     model_flat());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cfg_wr_valid = 1'b0;
    cfg_commit   = 1'b0;
    cfg_abort    = 1'b0;
    mon_tvalid   = 1'b0;
    mon_tready   = 1'b0;
    mon_tuser    = 1'b0;
  endtask

  task automatic frame_in();
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tuser  = 1'b1;
  endtask

  logic [FW-1:0] pf, all51f, exp4;

  initial begin
    pf = '0;
    pf[(NT/2)*CW +: CW] = 16'h7FFF;
    for (int k = 0; k < NT; k++) all51f[k*CW +: CW] = 16'h051F;
    exp4 = all51f;
    exp4[3*CW +: CW] = 16'h8000;

    // Reset state
    repeat (3) cyc();
    chk("rst_flat",    coe_flat,     pf);
    chk("rst_pending", cfg_pending,  1'b0);
    chk("rst_update",  coe_update,   1'b0);
    chk("rst_err",     cfg_err,      1'b0);
    reset = 1'b1;
    chk_en = 1'b1;
    cyc();
    chk("rel_ready", cfg_wr_ready, 1'b1);
    chk("rel_flat",  coe_flat,     pf);

    // Full-bank write, commit, frame start ten cycles later
    for (int k = 0; k < NT; k++) begin
      cfg_wr_valid = 1'b1;
      cfg_wr_addr  = 6'(k);
      cfg_wr_data  = 16'h051F;
      cyc();
    end
    idle_in();
    cfg_commit = 1'b1;
    cyc();
    idle_in();
    chk("c1_pending", cfg_pending,  1'b1);
    chk("c1_ready",   cfg_wr_ready, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("c1_hold_flat", coe_flat, pf);
      cyc();
    end
    frame_in();
    chk("c1_pre_flat", coe_flat, pf);
    cyc();
    idle_in();
    chk("c1_new_flat", coe_flat,    all51f);
    chk("c1_update",   coe_update,  1'b1);
    chk("c1_pend_off", cfg_pending, 1'b0);
    cyc();
    chk("c1_update_end", coe_update,   1'b0);
    chk("c1_ready_back", cfg_wr_ready, 1'b1);

    // Out-of-range write sets the sticky error, commit clears it
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = 6'd25;
    cfg_wr_data  = 16'h1234;
    cyc();
    idle_in();
    chk("oor_err_set", cfg_err, 1'b1);
    cfg_commit = 1'b1;
    cyc();
    idle_in();
    chk("oor_err_clr", cfg_err,     1'b0);
    chk("oor_pending", cfg_pending, 1'b1);
    frame_in();
    cyc();
    idle_in();
    chk("oor_flat",   coe_flat,   all51f);
    chk("oor_update", coe_update, 1'b1);
    cyc();

    // Commit, same-cycle write and frame start: no swap until a later frame start
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = 6'd3;
    cfg_wr_data  = 16'h8000;
    cfg_commit   = 1'b1;
    frame_in();
    cyc();
    idle_in();
    chk("same_pending", cfg_pending, 1'b1);
    chk("same_update",  coe_update,  1'b0);
    chk("same_flat",    coe_flat,    all51f);
    mon_tvalid = 1'b1;
    mon_tuser  = 1'b1;
    cyc();
    chk("nordy_pending", cfg_pending, 1'b1);
    chk("nordy_update",  coe_update,  1'b0);
    mon_tready = 1'b1;
    cyc();
    idle_in();
    chk("fs2_update", coe_update, 1'b1);
    chk("fs2_flat",   coe_flat,   exp4);
    cyc();

    // Abort coinciding with frame start wins
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = 6'd5;
    cfg_wr_data  = 16'h0001;
    cfg_commit   = 1'b1;
    cyc();
    idle_in();
    chk("ab_pending", cfg_pending, 1'b1);
    cfg_abort = 1'b1;
    frame_in();
    cyc();
    idle_in();
    chk("ab_pend_off", cfg_pending,  1'b0);
    chk("ab_ready",    cfg_wr_ready, 1'b1);
    chk("ab_update",   coe_update,   1'b0);
    chk("ab_flat",     coe_flat,     exp4);
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = 6'd6;
    cfg_wr_data  = 16'h0002;
    cyc();
    idle_in();

    // Out-of-range write in the commit cycle: set beats clear
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = 6'd63;
    cfg_wr_data  = 16'hAAAA;
    cfg_commit   = 1'b1;
    cyc();
    idle_in();
    chk("setclr_err",     cfg_err,     1'b1);
    chk("setclr_pending", cfg_pending, 1'b1);
    cfg_abort = 1'b1;
    cyc();
    idle_in();
    chk("setclr_abort", cfg_pending, 1'b0);
    cfg_abort  = 1'b1;
    cfg_commit = 1'b1;
    cyc();
    idle_in();
    chk("clr_err",         cfg_err,     1'b0);
    chk("idle_abort_pend", cfg_pending, 1'b1);
    cfg_abort = 1'b1;
    cyc();
    idle_in();

    // Reset pulsed mid-pending restores pass-through and drops the commit
    cfg_commit = 1'b1;
    cyc();
    idle_in();
    chk("rp_pending", cfg_pending, 1'b1);
    reset = 1'b0;
    #1;
    chk("rp_flat",    coe_flat,     pf);
    chk("rp_pend",    cfg_pending,  1'b0);
    chk("rp_ready",   cfg_wr_ready, 1'b1);
    chk("rp_update",  coe_update,   1'b0);
    cyc();
    reset = 1'b1;
    frame_in();
    cyc();
    chk("rp_fs_update", coe_update, 1'b0);
    cyc();
    idle_in();
    chk("rp_fs_update2", coe_update, 1'b0);
    chk("rp_fs_flat",    coe_flat,   pf);
    cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/filter_coe_ctrl.md
FILTER_COE_CTRL -- requirements
Module: filter_coe_ctrl

Interface
REQ-001 SHALL have parameter FILTER_DIM, default 5, filter kernel dimension (odd, 3..7).
REQ-002 SHALL have parameter COE_WIDTH, default 16, signed coefficient width (Q1.(COE_WIDTH-1)).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_wr_valid  input  1  coefficient write request.
REQ-006 SHALL have port cfg_wr_ready  output  1  coefficient write accepted when valid&ready.
REQ-007 SHALL have port cfg_wr_addr  input  6  tap index, i*FILTER_DIM+j.
REQ-008 SHALL have port cfg_wr_data  input  COE_WIDTH  signed coefficient.
REQ-009 SHALL have port cfg_commit  input  1  single-cycle request to apply shadow bank at next frame start.
REQ-010 SHALL have port cfg_abort  input  1  cancel a pending commit.
REQ-011 SHALL have port mon_tvalid, mon_tready, mon_tuser  input  1 each  monitor taps of the filter's input video stream.
REQ-012 SHALL have port coe_flat  output  FILTER_DIM*FILTER_DIM*COE_WIDTH  active bank; tap k at bits [k*COE_WIDTH +: COE_WIDTH].
REQ-013 SHALL have port coe_update  output  1  one-cycle pulse: active bank just changed.
REQ-014 SHALL have port cfg_pending  output  1  high while a commit awaits frame start.
REQ-015 SHALL have port cfg_err  output  1  sticky out-of-range address flag.

Function
REQ-016 SHALL keep two banks of FILTER_DIM^2 coefficients: shadow (written by cfg port) and active (drives coe_flat).
REQ-017 SHALL implement FSM states IDLE, PENDING, UPDATE.
REQ-018 IDLE: cfg_wr_ready=1; accepted write with addr < FILTER_DIM^2 stores cfg_wr_data into shadow[addr] at that edge.
REQ-019 IDLE: write with addr >= FILTER_DIM^2 SHALL be accepted, discarded, and set cfg_err.
REQ-020 IDLE + cfg_commit -> PENDING; a write accepted in the same cycle SHALL be included in the commit.
REQ-021 PENDING: cfg_wr_ready=0, cfg_pending=1; cfg_commit ignored.
REQ-022 PENDING: frame start = mon_tvalid & mon_tready & mon_tuser; on frame start in cycle N, active bank SHALL load whole shadow bank at end of N, FSM -> UPDATE.
REQ-023 Frame start in the same cycle as the commit is accepted (IDLE) SHALL NOT trigger the swap; next frame start does.
REQ-024 PENDING + cfg_abort -> IDLE with no swap; if abort and frame start coincide, abort SHALL win.
REQ-025 UPDATE: exactly one cycle; coe_update=1, cfg_wr_ready=0, cfg_pending=0; then -> IDLE.
REQ-026 Active bank SHALL change only on the PENDING->UPDATE edge; coe_flat is never partially updated.
REQ-027 cfg_err SHALL clear when a commit is accepted in a cycle with no out-of-range write; set takes priority over clear.
REQ-028 cfg_abort in IDLE or UPDATE SHALL be ignored.
REQ-029 All outputs SHALL be registered or decoded directly from the FSM state; no combinational path from inputs to outputs.

Reset
REQ-030 On reset low, asynchronously: FSM=IDLE, cfg_pending=0, coe_update=0, cfg_err=0.
REQ-031 On reset low, both banks SHALL load the pass-through kernel: centre tap (FILTER_DIM^2/2) = 2^(COE_WIDTH-1)-1 (0x7FFF at 16 bit), all others 0.
REQ-032 Reset asserted in PENDING SHALL discard the pending commit; no coe_update pulse follows.
REQ-033 cfg_wr_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 Reset release -> coe_flat centre tap 0x7FFF, others 0; cfg_wr_ready=1, cfg_pending=0.
REQ-035 Write all 25 taps 0x051F, commit, frame start 10 cycles later -> coe_flat unchanged until that edge, all taps 0x051F next cycle, coe_update high exactly 1 cycle.
REQ-036 Write addr 25 (value 0x1234), then commit -> cfg_err=1 before commit, shadow unchanged, cfg_err=0 after commit accepted.
REQ-037 Commit and frame start in the same cycle -> no swap; swap on the following frame start; mon_tuser with mon_tready=0 -> no swap.
REQ-038 PENDING, abort and frame start in the same cycle -> FSM IDLE, coe_flat unchanged, no coe_update; writes accepted next cycle.
REQ-039 Reset pulsed low mid-PENDING -> pass-through kernel restored immediately, a later frame start produces no coe_update.
